// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Logic and add/sub/compare ops complete in one cycle. Unsigned multiply
// runs a shift-add loop, one multiplier bit per cycle. At most one
// operation is in flight at a time.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic mul_last;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mhi;
  logic [WIDTH-1:0] mlo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_ext;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_err;

  // Reset holds in_ready low so nothing can be accepted on a reset edge.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_last  = (count == CW'(WIDTH - 1));

  // One shift-add step: add the multiplicand to the high half when the
  // current multiplier bit is set, then shift the whole {hi, lo} pair right.
  always_comb begin
    mul_sum     = {1'b0, mhi} + (mlo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], mlo[WIDTH-1:1]};
  end

  // Single-cycle ops; SUB and SLT share the adder as a + ~b + 1.
  always_comb begin
    is_sub     = (op == OP_SUB) || (op == OP_SLT);
    b_eff      = is_sub ? ~b : b;
    add_ext    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    alu_err    = 1'b0;
    case (op)
      OP_AND: alu_result = a & b;
      OP_OR:  alu_result = a | b;
      OP_NOR: alu_result = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_result = add_ext[WIDTH-1:0];
        alu_carry  = add_ext[WIDTH];
        alu_ovf    = add_ovf;
      end
      OP_SLT: begin
        alu_result = {{(WIDTH - 1){1'b0}}, add_ext[WIDTH-1] ^ add_ovf};
        alu_carry  = add_ext[WIDTH];
      end
      OP_MULU: alu_result = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the request/multiply/deliver sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (op == OP_MULU) ? MUL : DONE;
        end
      end
      MUL: begin
        if (mul_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, multiply iteration and result registers; results only
  // change when an operation completes, so they stay stable while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      mcand    <= '0;
      mhi      <= '0;
      mlo      <= '0;
      result   <= '0;
      hi       <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MULU) begin
              mcand <= a;
              mlo   <= b;
              mhi   <= '0;
              count <= '0;
            end else begin
              result   <= alu_result;
              hi       <= '0;
              zero     <= (alu_result == '0);
              carry    <= alu_carry;
              overflow <= alu_ovf;
              err      <= alu_err;
            end
          end
        end
        MUL: begin
          mhi   <= mul_hi_next;
          mlo   <= mul_lo_next;
          count <= count + CW'(1);
          if (mul_last) begin
            result   <= mul_lo_next;
            hi       <= mul_hi_next;
            zero     <= (mul_lo_next == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle (WIDTH=32): expected results come from an
// independent arithmetic model, are queued when a request is driven and
// popped when the DUT raises out_valid.
module tb_alu_multicycle;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam int         LIMIT   = 60;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] h;
    logic        z;
    logic        c;
    logic        v;
    logic        e;
  } out_t;

  typedef struct {
    out_t o;
    int   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        err;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .hi       (hi),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .err      (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference model built from wide integer arithmetic.
  function automatic out_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    out_t        m;
    logic [32:0] s;
    logic [63:0] p;
    longint      sx;
    m = '0;
    case (o)
      OP_AND: m.r = x & y;
      OP_OR:  m.r = x | y;
      OP_NOR: m.r = ~(x | y);
      OP_ADD: begin
        s   = {1'b0, x} + {1'b0, y};
        m.r = s[31:0];
        m.c = s[32];
        sx  = longint'($signed(x)) + longint'($signed(y));
        m.v = (sx != longint'($signed(m.r)));
      end
      OP_SUB: begin
        m.r = x - y;
        m.c = (x >= y);
        sx  = longint'($signed(x)) - longint'($signed(y));
        m.v = (sx != longint'($signed(m.r)));
      end
      OP_SLT: begin
        m.r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        m.c = (x >= y);
      end
      OP_MULU: begin
        p   = {32'd0, x} * {32'd0, y};
        m.r = p[31:0];
        m.h = p[63:32];
      end
      default: m.e = 1'b1;
    endcase
    m.z = (m.r == 32'd0);
    return m;
  endfunction

  function automatic out_t observe();
    return out_t'({result, hi, zero, carry, overflow, err});
  endfunction

  // Drives one request starting at the current negedge, queues its expected
  // result, then scrambles the inputs the cycle after acceptance.
  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t ex;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    ex.o     = model(o, x, y);
    ex.lat   = (o == OP_MULU) ? 33 : 1;
    sb.push_back(ex);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
  endtask

  // Counts cycles since acceptance until out_valid, bounded by a limit.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Completes the output handshake, returning at the negedge after it.
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if (observe() !== out_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h want 0", observe());
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_overflow();
    exp_t ex;
    int   lat;
    @(negedge clk);
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_out(lat);
    ex = sb.pop_front();
    checks++;
    if (lat !== ex.lat) begin
      errors++;
      $display("[TB] FAIL add_latency: got %0d want %0d", lat, ex.lat);
    end
    checks++;
    if (observe() !== ex.o) begin
      errors++;
      $display("[TB] FAIL add_outputs: got %h want %h", observe(), ex.o);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_sub_slt();
    exp_t        ex;
    int          lat;
    logic [3:0]  ops[2];
    logic [31:0] xs[2];
    logic [31:0] ys[2];
    ops = '{OP_SUB, OP_SLT};
    xs  = '{32'd5, 32'hFFFF_FFFF};
    ys  = '{32'd5, 32'd1};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      send(ops[i], xs[i], ys[i]);
      wait_out(lat);
      ex = sb.pop_front();
      checks++;
      if (lat !== ex.lat || observe() !== ex.o) begin
        errors++;
        $display("[TB] FAIL sub_slt_%0d: got lat=%0d out=%h want lat=%0d out=%h", i, lat, observe(), ex.lat, ex.o);
      end
      release_out();
    end
  endtask

  task automatic test_random_ops();
    exp_t        ex;
    int          lat;
    logic [3:0]  ops[6];
    logic [31:0] x;
    logic [31:0] y;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
    for (int i = 0; i < 24; i++) begin
      x = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      y = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
      @(negedge clk);
      send(ops[i % 6], x, y);
      wait_out(lat);
      ex = sb.pop_front();
      checks++;
      if (lat !== ex.lat || observe() !== ex.o) begin
        errors++;
        $display("[TB] FAIL random_op%0d_%0d: got lat=%0d out=%h want lat=%0d out=%h", ops[i % 6], i, lat, observe(), ex.lat, ex.o);
      end
      release_out();
    end
  endtask

  task automatic test_mulu();
    exp_t ex;
    int   lat;
    logic ready_seen;
    @(negedge clk);
    send(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat        = 1;
    ready_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < LIMIT) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    ex = sb.pop_front();
    checks++;
    if (lat !== ex.lat) begin
      errors++;
      $display("[TB] FAIL mulu_latency: got %0d want %0d", lat, ex.lat);
    end
    checks++;
    if (ready_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mulu_in_ready_busy: got 1 want 0");
    end
    checks++;
    if (observe() !== ex.o) begin
      errors++;
      $display("[TB] FAIL mulu_outputs: got %h want %h", observe(), ex.o);
    end
    release_out();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      send(OP_MULU, $urandom, (i == 0) ? 32'd0 : $urandom);
      wait_out(lat);
      ex = sb.pop_front();
      checks++;
      if (lat !== ex.lat || observe() !== ex.o) begin
        errors++;
        $display("[TB] FAIL mulu_rand_%0d: got lat=%0d out=%h want lat=%0d out=%h", i, lat, observe(), ex.lat, ex.o);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    exp_t ex;
    int   lat;
    @(negedge clk);
    send(OP_AND, 32'h0000_0AAA, 32'hFFFF_FFFF);
    wait_out(lat);
    ex = sb.pop_front();
    checks++;
    if (lat !== ex.lat || observe() !== ex.o) begin
      errors++;
      $display("[TB] FAIL hold_first: got lat=%0d out=%h want lat=%0d out=%h", lat, observe(), ex.lat, ex.o);
    end
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (observe() !== ex.o || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold_cycle_%0d: got out=%h ready=%b valid=%b want out=%h ready=0 valid=1", i, observe(), in_ready, out_valid, ex.o);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t ex;
    int   lat;
    @(negedge clk);
    send(OP_MULU, 32'hFFFF_FFFF, 32'h0000_0003);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || observe() !== out_t'(0)) begin
      errors++;
      $display("[TB] FAIL midmul_reset: got valid=%b ready=%b out=%h want 0 0 0", out_valid, in_ready, observe());
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midmul_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
    end
    send(OP_OR, 32'h0000_00F0, 32'h0000_000F);
    wait_out(lat);
    ex = sb.pop_front();
    checks++;
    if (lat !== ex.lat || observe() !== ex.o) begin
      errors++;
      $display("[TB] FAIL midmul_or: got lat=%0d out=%h want lat=%0d out=%h", lat, observe(), ex.lat, ex.o);
    end
    release_out();
  endtask

  task automatic test_illegal();
    exp_t       ex;
    int         lat;
    logic [3:0] ill[5];
    ill = '{4'b0101, 4'b0011, 4'b1001, 4'b1101, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      send(ill[i], $urandom, $urandom);
      wait_out(lat);
      ex = sb.pop_front();
      checks++;
      if (lat !== ex.lat || observe() !== ex.o) begin
        errors++;
        $display("[TB] FAIL illegal_op%0d: got lat=%0d out=%h want lat=%0d out=%h", ill[i], lat, observe(), ex.lat, ex.o);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    exp_t       ex;
    int         lat;
    logic [3:0] ops[6];
    ops       = '{OP_ADD, OP_SUB, OP_MULU, OP_NOR, OP_SLT, OP_AND};
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      send(ops[i], $urandom, $urandom);
      wait_out(lat);
      ex = sb.pop_front();
      checks++;
      if (lat !== ex.lat || observe() !== ex.o) begin
        errors++;
        $display("[TB] FAIL b2b_%0d: got lat=%0d out=%h want lat=%0d out=%h", i, lat, observe(), ex.lat, ex.o);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_idle_%0d: got valid=%b ready=%b want valid=0 ready=1", i, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  // Bounds the whole run in case the DUT never completes a handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 4'd0;
    a         = 32'd0;
    b         = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_random_ops();
    test_mulu();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal 4..64).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: op  input  4  operation code (REQ-011).
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have ports: out_valid output 1 result valid; out_ready input 1 consumer accepts result.
REQ-010 SHALL have outputs: result WIDTH low result word; hi WIDTH high product word; zero 1 result==0; carry 1 adder carry-out; overflow 1 signed overflow; err 1 illegal op.

Function
REQ-011 SHALL decode op: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b, as a + ~b + 1); 0111 SLT (signed a<b -> 1 else 0); 1100 NOR; 1000 MULU (unsigned a*b, 2*WIDTH product); all others illegal.
REQ-012 SHALL implement FSM states IDLE, MUL, DONE; in_ready SHALL be 1 only in IDLE and not while rst=1.
REQ-013 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1, capturing op, a, b; in_valid/op/a/b ignored otherwise.
REQ-014 SHALL go IDLE->DONE on accept of any non-MULU op; out_valid=1 the cycle after acceptance (latency 1).
REQ-015 SHALL go IDLE->MUL on accept of MULU; perform shift-add, one multiplier bit per cycle, for exactly WIDTH cycles, then DONE; out_valid=1 exactly WIDTH+1 cycles after acceptance.
REQ-016 SHALL hold result, hi, zero, carry, overflow, err stable in DONE while out_valid=1 and out_ready=0.
REQ-017 SHALL go DONE->IDLE on a rising edge with out_valid=1 and out_ready=1; out_valid=0 the next cycle; no new request accepted in the same cycle (max one in flight).
REQ-018 SHALL set hi=0 for every non-MULU op; for MULU result=product[WIDTH-1:0], hi=product[2*WIDTH-1:WIDTH], carry=0, overflow=0.
REQ-019 SHALL compute carry as adder carry-out for ADD/SUB/SLT (SUB: carry=1 means no borrow), 0 for logic ops.
REQ-020 SHALL compute overflow as signed overflow for ADD and SUB only; SLT SHALL use the overflow-corrected sign (sum_msb XOR overflow) and report overflow=0.
REQ-021 SHALL drive zero = (result == 0) for all legal ops, including MULU (low word only).
REQ-022 SHALL, for illegal op, complete with latency 1, result=0, hi=0, carry=0, overflow=0, zero=1, err=1; err=0 for legal ops.
REQ-023 SHALL wrap ADD/SUB results modulo 2^WIDTH.

Reset
REQ-024 SHALL, while rst=1 at a rising edge, force state IDLE, out_valid=0, result=0, hi=0, zero=0, carry=0, overflow=0, err=0, clear multiplier iteration counter.
REQ-025 SHALL abandon any MUL or DONE transaction on reset with no result delivered; rst has priority over all handshakes in the same cycle.
REQ-026 SHALL accept a request in the first cycle after rst deasserts.

Verification (WIDTH=32)
REQ-027 SHALL cover: ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, carry=0, out_valid 1 cycle after accept.
REQ-028 SHALL cover: SUB a=5 b=5 -> result 0, zero=1, carry=1; SLT a=0xFFFFFFFF b=1 -> result 1.
REQ-029 SHALL cover: MULU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, result=0x00000001, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-030 SHALL cover: AND a=0x00000AAA b=0xFFFFFFFF with out_ready=0 for 5 cycles -> result 0x00000AAA held stable, in_ready=0, then released on out_ready=1 and in_ready=1 next cycle.
REQ-031 SHALL cover: rst asserted 10 cycles into MULU -> out_valid stays 0, all outputs 0, in_ready=1 the cycle after rst deasserts; subsequent OR a=0xF0 b=0x0F -> 0xFF.
REQ-032 SHALL cover: op=0101 -> err=1, result=0, zero=1, latency 1.
